// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor record, reset-default divisor and interval-limit helper.
package uart_pkg;

  localparam int DEF_DIV_INT  = 27;
  localparam int DEF_DIV_FRAC = 2;
  localparam int CFG_CNT_W    = 16;
  localparam int CFG_FRAC_W   = 4;

  typedef struct packed {
    logic [CFG_CNT_W-1:0]  div_int;
    logic [CFG_FRAC_W-1:0] div_frac;
  } baud_cfg_t;

  // Terminal count of an interval: divisors 0 and 1 both give a one-cycle interval.
  function automatic logic [31:0] baud_lim(input logic [31:0] div_int, input logic carry);
    logic [31:0] base;
    base = (div_int > 32'd1) ? (div_int - 32'd1) : 32'd0;
    return base + {31'd0, carry};
  endfunction

endpackage

// File: rtl/uart_baud_frac_acc.sv
// Fractional phase accumulator; carry is valid only while adv is high and lengthens the next interval.
module uart_baud_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = adv & sum[FRAC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (adv) begin
      acc <= sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: os_tick every div_int + div_frac/2^FRAC_W cycles on average, bit_tick every OVS os_ticks.
module uart_baud_gen_frac #(
  parameter int CNT_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int DEF_DIV_INT  = uart_pkg::DEF_DIV_INT,
  parameter int DEF_DIV_FRAC = uart_pkg::DEF_DIV_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    resync,
  input  logic [CNT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  input  logic                    div_load,
  output logic                    div_pend,
  output logic                    os_tick,
  output logic                    bit_tick,
  output logic [$clog2(OVS)-1:0]  phase
);

  import uart_pkg::*;

  localparam int PH_W = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);

  typedef struct packed {
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
  } cfg_t;

  localparam cfg_t DEF_CFG = {CNT_W'(DEF_DIV_INT), FRAC_W'(DEF_DIV_FRAC)};

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  cfg_t             act;
  cfg_t             shd;
  cfg_t             load_cfg;
  cfg_t             eff_cfg;
  logic             nxt_pend;
  logic             hold;
  logic             at_end;
  logic             carry;

  // A load in the same cycle as an interval end or a hold takes effect immediately.
  always_comb begin
    load_cfg = {div_int, div_frac};
    nxt_pend = div_load | div_pend;
    eff_cfg  = act;
    if (div_load) begin
      eff_cfg = load_cfg;
    end else if (div_pend) begin
      eff_cfg = shd;
    end
    hold   = ~en | resync;
    at_end = ~hold && (cnt == lim);
  end

  uart_baud_frac_acc #(
    .FRAC_W(FRAC_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (hold),
    .adv  (at_end),
    .frac (eff_cfg.div_frac),
    .carry(carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lim      <= CNT_W'(baud_lim(32'(DEF_DIV_INT), 1'b0));
      act      <= DEF_CFG;
      shd      <= DEF_CFG;
      div_pend <= 1'b0;
      phase    <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      if (div_load) begin
        shd <= load_cfg;
      end
      if (hold) begin
        cnt      <= '0;
        phase    <= '0;
        act      <= eff_cfg;
        div_pend <= 1'b0;
        lim      <= CNT_W'(baud_lim(32'(eff_cfg.div_int), 1'b0));
      end else if (at_end) begin
        cnt      <= '0;
        act      <= eff_cfg;
        div_pend <= 1'b0;
        lim      <= CNT_W'(baud_lim(32'(eff_cfg.div_int), carry));
        os_tick  <= 1'b1;
        bit_tick <= (phase == PH_LAST);
        phase    <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end else begin
        cnt      <= cnt + 1'b1;
        div_pend <= nxt_pend;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: directed interval measurements plus randomized run against a tick-schedule model.
module tb_uart_baud_gen_frac;

  localparam int OVS  = 16;
  localparam int FDEN = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        resync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        div_pend;
  logic        os_tick;
  logic        bit_tick;
  logic [3:0]  phase;

  int checks = 0;
  int errors = 0;

  // Reference model: schedules absolute tick times from the interval-length rule.
  int m_act_d, m_act_f, m_shd_d, m_shd_f, m_pend;
  int m_cyc, m_nxt, m_sum, m_nt, m_os, m_bit;

  always #5 clk = ~clk;

  uart_baud_gen_frac #(
    .CNT_W(16), .FRAC_W(4), .OVS(OVS), .DEF_DIV_INT(27), .DEF_DIV_FRAC(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .div_pend(div_pend), .os_tick(os_tick), .bit_tick(bit_tick), .phase(phase)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dmax(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  task automatic model_step();
    int np, e_d, e_f, c;
    if (rst) begin
      m_act_d = 27; m_act_f = 2; m_pend = 0;
      m_cyc = 0; m_nxt = 27; m_sum = 0; m_nt = 0; m_os = 0; m_bit = 0;
      return;
    end
    np = (m_pend != 0 || div_load) ? 1 : 0;
    if (div_load) begin
      m_shd_d = int'(div_int);
      m_shd_f = int'(div_frac);
    end
    e_d = np ? m_shd_d : m_act_d;
    e_f = np ? m_shd_f : m_act_f;
    if (!en || resync) begin
      m_act_d = e_d; m_act_f = e_f; m_pend = 0;
      m_cyc = 0; m_nxt = dmax(e_d); m_sum = 0; m_nt = 0; m_os = 0; m_bit = 0;
    end else begin
      m_cyc++;
      if (m_cyc == m_nxt) begin
        m_act_d = e_d; m_act_f = e_f; m_pend = 0;
        c = (m_sum + e_f) / FDEN - m_sum / FDEN;
        m_sum += e_f;
        m_nt++;
        m_nxt = m_cyc + dmax(e_d) + c;
        m_os  = 1;
        m_bit = (m_nt % OVS == 0) ? 1 : 0;
      end else begin
        m_pend = np;
        m_os = 0;
        m_bit = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("os_tick", int'(os_tick), m_os);
    chk("bit_tick", int'(bit_tick), m_bit);
    chk("phase", int'(phase), m_nt % OVS);
    chk("div_pend", int'(div_pend), m_pend);
  endtask

  task automatic wait_os(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (os_tick !== 1'b1 && n < 1000);
    if (os_tick !== 1'b1) chk("os_timeout", 0, 1);
  endtask

  task automatic start(input int d, input int f);
    en = 1'b0;
    div_int = 16'(d);
    div_frac = 4'(f);
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tick();
    en = 1'b1;
  endtask

  initial begin
    int n, s, k, pp, pc, ln;
    rst = 1'b1; en = 1'b0; resync = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;

    // Reset defaults: first tick after 27 cycles, then 16 intervals of 434 cycles.
    tick();
    tick();
    chk("rst_os", int'(os_tick), 0);
    chk("rst_pend", int'(div_pend), 0);
    rst = 1'b0;
    en = 1'b1;
    wait_os(n);
    chk("def_first", n, 27);
    s = 0;
    for (int i = 0; i < 16; i++) begin
      wait_os(n);
      s += n;
    end
    chk("def_16_intervals", s, 434);

    // Integer divisor 4: bit_tick every 64 cycles with phase wrapping 15 -> 0.
    start(4, 0);
    for (int r = 0; r < 2; r++) begin
      n = 0; pp = 0;
      do begin
        pp = int'(phase);
        tick();
        n++;
      end while (bit_tick !== 1'b1 && n < 1000);
      chk("int_bit_period", n, 64);
      chk("int_phase_before", pp, 15);
      chk("int_phase_wrap", int'(phase), 0);
    end

    // Fractional divisor 4 + 8/16.
    start(4, 8);
    wait_os(n);
    chk("frac_first", n, 4);
    s = 0;
    for (int i = 0; i < 16; i++) begin
      wait_os(n);
      s += n;
    end
    chk("frac_16_intervals", s, 72);

    // Mid-run load of 10/0 issued in the cycle showing an os_tick.
    start(4, 0);
    wait_os(n);
    wait_os(n);
    div_int = 16'd10; div_frac = 4'd0; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    pc = int'(div_pend); ln = 1;
    while (os_tick !== 1'b1 && ln < 100) begin
      tick();
      ln++;
      pc += int'(div_pend);
    end
    chk("load_pend_cycles", pc, 3);
    chk("load_cur_interval", ln, 4);
    wait_os(n);
    chk("load_new_interval", n, 10);
    // Two loads before the interval end: the last one wins.
    div_int = 16'd8; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tick();
    div_int = 16'd6; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    wait_os(n);
    chk("reload_cur_interval", n + 3, 10);
    wait_os(n);
    chk("reload_last_wins", n, 6);
    wait_os(n);
    chk("reload_steady", n, 6);

    // Resync at phase 7, cnt 2.
    start(4, 0);
    for (int i = 0; i < 7; i++) wait_os(n);
    chk("resync_phase_pre", int'(phase), 7);
    tick();
    tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_no_tick", int'(os_tick), 0);
    wait_os(n);
    chk("resync_first", n, 4);
    chk("resync_phase", int'(phase), 1);
    k = 1;
    while (bit_tick !== 1'b1 && k < 40) begin
      wait_os(n);
      k++;
    end
    chk("resync_bit_after", k, 16);

    // Dropping en and asserting rst mid-interval.
    wait_os(n);
    tick();
    en = 1'b0;
    tick();
    chk("en_drop_os", int'(os_tick), 0);
    chk("en_drop_phase", int'(phase), 0);
    en = 1'b1;
    wait_os(n);
    chk("en_restart", n, 4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_os", int'(os_tick), 0);
    chk("rst_mid_phase", int'(phase), 0);
    wait_os(n);
    chk("rst_default_back", n, 27);

    // Divisor 0 behaves as 1: os_tick every cycle.
    start(0, 0);
    s = 0; k = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      s += int'(os_tick);
      k += int'(bit_tick);
    end
    chk("div0_os_count", s, 32);
    chk("div0_bit_count", k, 2);

    // Randomized run checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      resync = ($urandom_range(0, 199) == 0);
      div_load = ($urandom_range(0, 39) == 0);
      div_int = 16'($urandom_range(0, 7));
      div_frac = 4'($urandom_range(0, 15));
      if (en && $urandom_range(0, 149) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
      tick();
    end
    rst = 1'b0; resync = 1'b0; div_load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
